// File: rtl/oqpsk_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : oqpsk_frame_gen
//  Description : Serial frame generator for an OQPSK modulator. Emits a
//                1010... preamble, a 16-bit sync word and a whitened payload
//                fed byte-by-byte through a single holding register. Every
//                frame bit is held for BIT_DIV clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module oqpsk_frame_gen #(
    parameter int          PRE_LEN   = 32,
    parameter logic [15:0] SYNC_WORD = 16'hD391,
    parameter int          PAY_BYTES = 8,
    parameter int          BIT_DIV   = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic [7:0] DataIn,
    input  logic       DataValid,
    output logic       DataReady,
    output logic       BitOut,
    output logic       EN,
    output logic       Busy,
    output logic       Done,
    output logic       Underrun
);

    localparam int c_DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int c_PAY_BITS = PAY_BYTES * 8;
    localparam int c_CNT_MAX  = (PRE_LEN > c_PAY_BITS) ?
                                ((PRE_LEN > 16) ? PRE_LEN : 16) :
                                ((c_PAY_BITS > 16) ? c_PAY_BITS : 16);
    localparam int c_CNT_W    = $clog2(c_CNT_MAX);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(BIT_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_PRE_LAST  = c_CNT_W'(PRE_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(15);
    localparam logic [c_CNT_W-1:0] c_PAY_LAST  = c_CNT_W'(c_PAY_BITS - 1);
    localparam logic [6:0]         c_LFSR_SEED = 7'h7F;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PRE  = 2'd1;
    localparam logic [1:0] c_ST_SYNC = 2'd2;
    localparam logic [1:0] c_ST_PAY  = 2'd3;

    logic [1:0]         r_state,     w_state_nxt;
    logic [c_DIV_W-1:0] r_div,       w_div_nxt;
    logic [c_CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [6:0]         r_lfsr,      w_lfsr_nxt;
    logic [7:0]         r_shift,     w_shift_nxt;
    logic [7:0]         r_hold,      w_hold_nxt;
    logic               r_hold_full, w_hold_full_nxt;
    logic               r_bit,       w_bit_nxt;
    logic               r_en,        w_en_nxt;
    logic               r_done,      w_done_nxt;
    logic               r_ready,     w_ready_nxt;
    logic               r_underrun,  w_underrun_nxt;
    logic               r_busy;

    logic               w_wrap;
    logic               w_accept;
    logic [6:0]         w_lfsr_step;
    logic [7:0]         w_load_byte;
    logic [3:0]         w_sync_idx;

    assign w_wrap      = (r_div == c_DIV_LAST);
    assign w_accept    = DataValid & r_ready;
    assign w_lfsr_step = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[3]};
    // An empty holding register at a byte boundary starves the shifter with zeros
    assign w_load_byte = r_hold_full ? r_hold : 8'h00;
    assign w_sync_idx  = 4'd14 - r_cnt[3:0];

    // Next-state and next-output computation; every output is registered
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lfsr_nxt      = r_lfsr;
        w_shift_nxt     = r_shift;
        w_bit_nxt       = r_bit;
        w_en_nxt        = r_en;
        w_done_nxt      = 1'b0;
        w_underrun_nxt  = r_underrun;
        w_hold_nxt      = w_accept ? DataIn : r_hold;
        w_hold_full_nxt = r_hold_full | w_accept;
        w_div_nxt       = (r_state == c_ST_IDLE || w_wrap) ? '0 : r_div + c_DIV_W'(1);

        case (r_state)
            c_ST_IDLE: begin
                if (Start) begin
                    w_state_nxt    = c_ST_PRE;
                    w_cnt_nxt      = '0;
                    w_bit_nxt      = 1'b1;
                    w_en_nxt       = 1'b1;
                    w_underrun_nxt = 1'b0;
                end
            end
            c_ST_PRE: begin
                if (w_wrap) begin
                    if (r_cnt == c_PRE_LAST) begin
                        w_state_nxt = c_ST_SYNC;
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = SYNC_WORD[15];
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        // bit index cnt+1 is odd exactly when cnt is even
                        w_bit_nxt = r_cnt[0];
                    end
                end
            end
            c_ST_SYNC: begin
                if (w_wrap) begin
                    if (r_cnt == c_SYNC_LAST) begin
                        // First payload byte boundary; LFSR restarts at the seed
                        w_state_nxt     = c_ST_PAY;
                        w_cnt_nxt       = '0;
                        w_lfsr_nxt      = c_LFSR_SEED;
                        w_bit_nxt       = w_load_byte[7] ^ c_LFSR_SEED[6];
                        w_shift_nxt     = {w_load_byte[6:0], 1'b0};
                        w_hold_full_nxt = w_accept;
                        w_underrun_nxt  = r_underrun | ~r_hold_full;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                        w_bit_nxt = SYNC_WORD[w_sync_idx];
                    end
                end
            end
            c_ST_PAY: begin
                if (w_wrap) begin
                    if (r_cnt == c_PAY_LAST) begin
                        // End of frame: any byte still held is dropped
                        w_state_nxt     = c_ST_IDLE;
                        w_cnt_nxt       = '0;
                        w_bit_nxt       = 1'b0;
                        w_en_nxt        = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_hold_full_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt  = r_cnt + c_CNT_W'(1);
                        w_lfsr_nxt = w_lfsr_step;
                        if (r_cnt[2:0] == 3'd7) begin
                            w_bit_nxt       = w_load_byte[7] ^ w_lfsr_step[6];
                            w_shift_nxt     = {w_load_byte[6:0], 1'b0};
                            w_hold_full_nxt = w_accept;
                            w_underrun_nxt  = r_underrun | ~r_hold_full;
                        end else begin
                            w_bit_nxt   = r_shift[7] ^ w_lfsr_step[6];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_en_nxt    = 1'b0;
                w_bit_nxt   = 1'b0;
            end
        endcase

        w_ready_nxt = ((w_state_nxt == c_ST_SYNC) || (w_state_nxt == c_ST_PAY)) & ~w_hold_full_nxt;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= c_ST_IDLE;
            r_div       <= '0;
            r_cnt       <= '0;
            r_lfsr      <= c_LFSR_SEED;
            r_shift     <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_bit       <= 1'b0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_bit       <= w_bit_nxt;
            r_en        <= w_en_nxt;
            r_busy      <= (w_state_nxt != c_ST_IDLE);
            r_done      <= w_done_nxt;
            r_ready     <= w_ready_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

    assign DataReady = r_ready;
    assign BitOut    = r_bit;
    assign EN        = r_en;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_oqpsk_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oqpsk_frame_gen
//  Description : Directed self-checking bench for oqpsk_frame_gen. A default
//                instance covers the full frame, zero payload, starvation,
//                restart and mid-frame reset; a small instance covers the
//                minimum-size frame timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oqpsk_frame_gen;

    localparam int c_DIV   = 16;
    localparam int c_BITS  = 32 + 16 + 64;
    localparam int c_LEN   = c_BITS * c_DIV;
    localparam int c_PAY0  = (32 + 16) * c_DIV;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic       DataValid = 1'b0;
    logic       DataReady, BitOut, EN, Busy, Done, Underrun;

    logic       s_start = 1'b0;
    logic [7:0] s_din = 8'h00;
    logic       s_dv = 1'b0;
    logic       s_ready, s_bit, s_en, s_busy, s_done, s_ur;

    always #5 clk = ~clk;

    oqpsk_frame_gen dut (
        .CLK(clk), .RST(RST), .Start(Start), .DataIn(DataIn), .DataValid(DataValid),
        .DataReady(DataReady), .BitOut(BitOut), .EN(EN), .Busy(Busy), .Done(Done),
        .Underrun(Underrun)
    );

    oqpsk_frame_gen #(.PRE_LEN(2), .SYNC_WORD(16'hD391), .PAY_BYTES(1), .BIT_DIV(2)) dut_s (
        .CLK(clk), .RST(RST), .Start(s_start), .DataIn(s_din), .DataValid(s_dv),
        .DataReady(s_ready), .BitOut(s_bit), .EN(s_en), .Busy(s_busy), .Done(s_done),
        .Underrun(s_ur)
    );

    int         n_cmp = 0;
    int         n_err = 0;

    logic       samp[$];
    logic [7:0] bytes[10];
    logic       exp_bits[c_BITS];
    int         n_done, done_pos, busy_bad, n_acc;
    logic       done_en, ur_first, ur_pay, ur_end;
    int         bad_bits, bad_hold;
    logic [31:0] obs_pre;
    logic [15:0] obs_sync;
    logic [7:0]  obs_pay0;

    // Reference frame built straight from the frame definition
    task automatic build_exp(input bit feed);
        logic [6:0]  l;
        logic [7:0]  d;
        logic [15:0] sw;
        sw = 16'hD391;
        for (int i = 0; i < 32; i++) exp_bits[i] = (i % 2 == 0);
        for (int i = 0; i < 16; i++) exp_bits[32 + i] = sw[15 - i];
        l = 7'h7F;
        for (int k = 0; k < 8; k++) begin
            d = feed ? bytes[k] : 8'h00;
            for (int b = 7; b >= 0; b--) begin
                exp_bits[48 + k * 8 + (7 - b)] = d[b] ^ l[6];
                l = {l[5:0], l[6] ^ l[3]};
            end
        end
    endtask

    // Runs one frame on the default instance, recording every EN-high BitOut
    task automatic capture_frame(input bit feed, input int start_again);
        int  idx;
        logic acc;
        samp.delete();
        n_done = 0; done_pos = -1; busy_bad = 0; idx = 0; done_en = 1'bx;
        ur_first = 1'bx; ur_pay = 1'bx;
        @(negedge clk);
        Start = 1'b1; DataValid = feed; DataIn = bytes[0];
        acc = feed && DataReady;
        @(negedge clk);
        Start = 1'b0;
        for (int c = 0; c < c_LEN + 40; c++) begin
            if (acc) idx++;
            if (EN) begin
                if (samp.size() == 0) ur_first = Underrun;
                if (samp.size() == c_PAY0) ur_pay = Underrun;
                samp.push_back(BitOut);
            end
            if (Busy !== EN) busy_bad++;
            if (Done) begin
                n_done++; done_pos = samp.size(); done_en = EN;
            end
            Start     = (start_again > 0 && samp.size() == start_again);
            DataIn    = bytes[idx > 9 ? 9 : idx];
            DataValid = feed;
            acc       = feed && DataReady;
            @(negedge clk);
        end
        DataValid = 1'b0;
        Start = 1'b0;
        ur_end = Underrun;
        n_acc = idx;
    endtask

    // Reduces the captured samples to per-bit values and hold violations
    task automatic measure;
        bad_bits = 0; bad_hold = 0;
        obs_pre = 'x; obs_sync = 'x; obs_pay0 = 'x;
        for (int i = 0; i < c_BITS; i++) begin
            if (samp.size() >= (i + 1) * c_DIV) begin
                if (samp[i * c_DIV] !== exp_bits[i]) bad_bits++;
                for (int j = 1; j < c_DIV; j++)
                    if (samp[i * c_DIV + j] !== samp[i * c_DIV]) bad_hold++;
                if (i < 32) obs_pre[31 - i] = samp[i * c_DIV];
                else if (i < 48) obs_sync[47 - i] = samp[i * c_DIV];
                else if (i < 56) obs_pay0[55 - i] = samp[i * c_DIV];
            end else begin
                bad_bits++;
            end
        end
    endtask

    task automatic set_bytes(input logic [7:0] base, input logic [7:0] step);
        for (int k = 0; k < 10; k++) bytes[k] = base + step * 8'(k);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({EN, BitOut, Busy, Done, DataReady, Underrun} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000", {EN, BitOut, Busy, Done, DataReady, Underrun});
        end
        n_cmp++;
        if ({s_en, s_bit, s_busy, s_done, s_ready, s_ur} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs_small: got %b want 000000", {s_en, s_bit, s_busy, s_done, s_ready, s_ur});
        end
        RST = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        set_bytes(8'h11, 8'h3B);
        build_exp(1'b1);
        capture_frame(1'b1, -1);
        measure();
        n_cmp++; if (samp.size() !== c_LEN) begin n_err++; $display("FAIL basic_len: got %0d want %0d", samp.size(), c_LEN); end
        n_cmp++; if (obs_pre !== 32'hAAAAAAAA) begin n_err++; $display("FAIL basic_preamble: got %h want aaaaaaaa", obs_pre); end
        n_cmp++; if (obs_sync !== 16'hD391) begin n_err++; $display("FAIL basic_sync: got %h want d391", obs_sync); end
        n_cmp++; if (obs_pay0 !== (8'h11 ^ 8'hFE)) begin n_err++; $display("FAIL basic_pay0: got %h want %h", obs_pay0, 8'h11 ^ 8'hFE); end
        n_cmp++; if (bad_bits !== 0) begin n_err++; $display("FAIL basic_bits: got %0d wrong bits want 0", bad_bits); end
        n_cmp++; if (bad_hold !== 0) begin n_err++; $display("FAIL basic_hold: got %0d hold errors want 0", bad_hold); end
        n_cmp++; if (n_done !== 1 || done_pos !== c_LEN || done_en !== 1'b0) begin
            n_err++; $display("FAIL basic_done: got count %0d pos %0d en %b want 1 %0d 0", n_done, done_pos, done_en, c_LEN);
        end
        n_cmp++; if (busy_bad !== 0) begin n_err++; $display("FAIL basic_busy: got %0d busy/en disagreements want 0", busy_bad); end
        n_cmp++; if (ur_end !== 1'b0) begin n_err++; $display("FAIL basic_underrun: got %b want 0", ur_end); end
        n_cmp++; if (n_acc !== 9) begin n_err++; $display("FAIL basic_accepted: got %0d want 9", n_acc); end
    endtask

    task automatic test_zero_payload;
        set_bytes(8'h00, 8'h00);
        build_exp(1'b1);
        capture_frame(1'b1, -1);
        measure();
        n_cmp++; if (obs_pay0 !== 8'hFE) begin n_err++; $display("FAIL zero_pay0: got %h want fe", obs_pay0); end
        n_cmp++; if (bad_bits !== 0) begin n_err++; $display("FAIL zero_bits: got %0d wrong bits want 0", bad_bits); end
    endtask

    task automatic test_underrun;
        set_bytes(8'hC3, 8'h17);
        build_exp(1'b0);
        capture_frame(1'b0, -1);
        measure();
        n_cmp++; if (ur_first !== 1'b0) begin n_err++; $display("FAIL starve_ur_pre: got %b want 0", ur_first); end
        n_cmp++; if (ur_pay !== 1'b1) begin n_err++; $display("FAIL starve_ur_pay: got %b want 1", ur_pay); end
        n_cmp++; if (ur_end !== 1'b1) begin n_err++; $display("FAIL starve_ur_sticky: got %b want 1", ur_end); end
        n_cmp++; if (samp.size() !== c_LEN) begin n_err++; $display("FAIL starve_len: got %0d want %0d", samp.size(), c_LEN); end
        n_cmp++; if (bad_bits !== 0) begin n_err++; $display("FAIL starve_bits: got %0d wrong bits want 0", bad_bits); end
        n_cmp++; if (n_acc !== 0) begin n_err++; $display("FAIL starve_accepted: got %0d want 0", n_acc); end
        // The next accepted Start clears the sticky flag
        set_bytes(8'h5A, 8'h21);
        build_exp(1'b1);
        capture_frame(1'b1, -1);
        measure();
        n_cmp++; if (ur_first !== 1'b0) begin n_err++; $display("FAIL starve_clear: got %b want 0", ur_first); end
        n_cmp++; if (bad_bits !== 0) begin n_err++; $display("FAIL starve_next_bits: got %0d wrong bits want 0", bad_bits); end
    endtask

    task automatic test_restart_ignored;
        set_bytes(8'h9C, 8'h45);
        build_exp(1'b1);
        capture_frame(1'b1, c_PAY0 + 32 * c_DIV);
        measure();
        n_cmp++; if (samp.size() !== c_LEN) begin n_err++; $display("FAIL restart_len: got %0d want %0d", samp.size(), c_LEN); end
        n_cmp++; if (bad_bits !== 0 || bad_hold !== 0) begin n_err++; $display("FAIL restart_bits: got %0d/%0d errors want 0/0", bad_bits, bad_hold); end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL restart_done: got %0d want 1", n_done); end
    endtask

    task automatic test_reset_mid;
        int cnt, guard, seen_done, seen_en;
        set_bytes(8'h33, 8'h11);
        @(negedge clk);
        Start = 1'b1; DataValid = 1'b1; DataIn = bytes[0];
        @(negedge clk);
        Start = 1'b0;
        cnt = 0; guard = 0;
        while (cnt < 40 * c_DIV && guard < 2000) begin
            if (EN) cnt++;
            guard++;
            @(negedge clk);
        end
        n_cmp++; if (cnt !== 40 * c_DIV) begin n_err++; $display("FAIL midrst_reach_sync: got %0d en cycles want %0d", cnt, 40 * c_DIV); end
        RST = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({EN, Busy, Done, BitOut, DataReady} !== 5'b0) begin
            n_err++; $display("FAIL midrst_outputs: got %b want 00000", {EN, Busy, Done, BitOut, DataReady});
        end
        RST = 1'b0;
        seen_done = 0; seen_en = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (Done) seen_done++;
            if (EN) seen_en++;
        end
        DataValid = 1'b0;
        n_cmp++; if (seen_done !== 0 || seen_en !== 0) begin n_err++; $display("FAIL midrst_quiet: got done %0d en %0d want 0 0", seen_done, seen_en); end
        test_basic();
    endtask

    task automatic test_small;
        logic sq[$];
        logic [25:0] obs, expv;
        int  acc_n, c_first, c_done, bad_h, cyc;
        logic acc, pulsed;
        sq.delete();
        expv = {2'b10, 16'hD391, 8'hA5 ^ 8'hFE};
        obs = 'x; acc_n = 0; c_first = -1; c_done = -1; bad_h = 0; cyc = 0;
        acc = 1'b0; pulsed = 1'b0;
        s_din = 8'hA5;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (acc) acc_n++;
            if (s_en) begin
                if (c_first < 0) c_first = cyc;
                sq.push_back(s_bit);
            end
            if (s_done && c_done < 0) c_done = cyc;
            s_dv = (!pulsed && s_ready);
            if (s_dv) pulsed = 1'b1;
            acc = s_dv && s_ready;
            cyc++;
            @(negedge clk);
        end
        s_dv = 1'b0;
        for (int i = 0; i < 26; i++) begin
            if (sq.size() >= 2 * i + 2) begin
                obs[25 - i] = sq[2 * i];
                if (sq[2 * i + 1] !== sq[2 * i]) bad_h++;
            end
        end
        n_cmp++; if (sq.size() !== 52) begin n_err++; $display("FAIL small_len: got %0d want 52", sq.size()); end
        n_cmp++; if (obs !== expv) begin n_err++; $display("FAIL small_bits: got %b want %b", obs, expv); end
        n_cmp++; if (bad_h !== 0) begin n_err++; $display("FAIL small_hold: got %0d hold errors want 0", bad_h); end
        n_cmp++; if (acc_n !== 1) begin n_err++; $display("FAIL small_accepted: got %0d want 1", acc_n); end
        n_cmp++; if (c_done - c_first !== 52 || c_first < 0) begin n_err++; $display("FAIL small_done_gap: got %0d want 52", c_done - c_first); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_payload();
        test_underrun();
        test_restart_ignored();
        test_reset_mid();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
